// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM state encoding and
// the result codes used to summarise an eq/gt/lt outcome.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] RES_EQ = 2'd0;
    localparam logic [1:0] RES_GT = 2'd1;
    localparam logic [1:0] RES_LT = 2'd2;

endpackage

// File: rtl/serial_mag_compare_bit_cmp_cell.sv
// Combinational 1-bit compare cell (module bit_cmp_cell): reports equality,
// inequality and the unsigned greater/less relation of a single bit pair.
module bit_cmp_cell (
    input  logic a,
    input  logic b,
    output logic eq,
    output logic ne,
    output logic gt,
    output logic lt
);

    assign eq = ~(a ^ b);
    assign ne = a ^ b;
    assign gt = a & ~b;
    assign lt = ~a & b;

endmodule

// File: rtl/serial_mag_compare.sv
// Bit-serial unsigned magnitude comparator, MSB first, one bit pair per clock.
// Optional macro SERIAL_CMP_EARLY_TERM_EN ends the scan at the first difference.
module serial_mag_compare
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int POS_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic             eq,
    output logic             gt,
    output logic             lt,
    output logic [POS_W-1:0] diff_pos
);

    // Handshake: start is a request taken only in IDLE (busy=0); operands are
    // captured on that edge. done is a one-cycle valid pulse for eq/gt/lt/diff_pos,
    // which then hold until the next accepted start. No back-pressure on the result.

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [POS_W-1:0] idx;
    logic             decided;

    logic cell_eq;
    logic cell_ne;
    logic cell_gt;
    logic cell_lt;

    bit_cmp_cell u_cell (
        .a  (a_sh[WIDTH-1]),
        .b  (b_sh[WIDTH-1]),
        .eq (cell_eq),
        .ne (cell_ne),
        .gt (cell_gt),
        .lt (cell_lt)
    );

    logic hit;
    logic gt_next;
    logic lt_next;
    logic finish;

    // First differing bit only; once decided, later bits are ignored.
    assign hit     = ~decided & cell_ne & ~cell_eq;
    assign gt_next = gt | (hit & cell_gt);
    assign lt_next = lt | (hit & cell_lt);

`ifdef SERIAL_CMP_EARLY_TERM_EN
    assign finish = (idx == '0) | hit;
`else
    assign finish = (idx == '0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            a_sh     <= '0;
            b_sh     <= '0;
            idx      <= '0;
            decided  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            eq       <= 1'b0;
            gt       <= 1'b0;
            lt       <= 1'b0;
            diff_pos <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh     <= a_in;
                        b_sh     <= b_in;
                        idx      <= POS_W'(WIDTH - 1);
                        decided  <= 1'b0;
                        eq       <= 1'b0;
                        gt       <= 1'b0;
                        lt       <= 1'b0;
                        diff_pos <= '0;
                        busy     <= 1'b1;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (hit) begin
                        gt       <= cell_gt;
                        lt       <= cell_lt;
                        diff_pos <= idx;
                        decided  <= 1'b1;
                    end
                    a_sh <= a_sh << 1;
                    b_sh <= b_sh << 1;
                    idx  <= idx - 1'b1;
                    if (finish) begin
                        eq    <= ~(gt_next | lt_next);
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
